// File: rtl/uart_rx.sv
// UART receiver for the colour-detector link: 11-bit frames (start, 8 data MSB first, even parity, stop).
// Optional stop-bit checking is enabled by defining UART_RX_FRAME_ERR_EN.
module uart_rx #(
    parameter int          CLKS_PER_BIT = 14,
    parameter logic [7:0]  ERR_CHAR     = 8'h3F
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_msg,
    output logic       rx_parity,
    output logic       rx_complete
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          p_rx, p_rx_n;
    logic [7:0]    msg_n;
    logic          par_n;
    logic          done_n;
`ifdef UART_RX_FRAME_ERR_EN
    logic          stop_bad, stop_bad_n;
`endif

    logic at_mid, at_last;
    assign at_mid  = (clk_cnt == CNT_MID);
    assign at_last = (clk_cnt == CNT_LAST);

    // clk_cnt holds cycles already spent in the current bit; the IDLE edge that sees
    // the start bit counts as cycle 1, so the stop bit ends on frame cycle 11*CLKS_PER_BIT.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_n   = state;
        clk_cnt_n = at_last ? '0 : clk_cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        p_rx_n    = p_rx;
        msg_n     = rx_msg;
        par_n     = rx_parity;
        done_n    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        stop_bad_n = stop_bad;
`endif

        unique case (state)
            IDLE: begin
                clk_cnt_n = '0;
                bit_idx_n = '0;
                if (!rx) begin
                    state_n   = START;
                    clk_cnt_n = CW'(1);
                end
            end
            START: begin
                if (at_mid && rx) begin
                    state_n   = IDLE;
                    clk_cnt_n = '0;
                end else if (at_last) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (at_mid)
                    shreg_n = {shreg[6:0], rx};
                if (at_last) begin
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7)
                        state_n = PARITY;
                end
            end
            PARITY: begin
                if (at_mid)
                    p_rx_n = rx;
                if (at_last)
                    state_n = STOP;
            end
            STOP: begin
`ifdef UART_RX_FRAME_ERR_EN
                if (at_mid)
                    stop_bad_n = !rx;
`endif
                if (at_last) begin
                    done_n  = 1'b1;
                    par_n   = p_rx;
                    msg_n   = (p_rx == ^shreg) ? shreg : ERR_CHAR;
                    state_n = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                    if (stop_bad) begin
                        msg_n = ERR_CHAR;
                        // A line still held low would otherwise look like a new start bit.
                        if (!rx)
                            state_n = WAIT_HIGH;
                    end
                    stop_bad_n = 1'b0;
`endif
                end
            end
            WAIT_HIGH: begin
                clk_cnt_n = '0;
                if (rx)
                    state_n = IDLE;
            end
            default: begin
                state_n   = IDLE;
                clk_cnt_n = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            p_rx        <= 1'b0;
            rx_msg      <= 8'h00;
            rx_parity   <= 1'b0;
            rx_complete <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            stop_bad    <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            p_rx        <= p_rx_n;
            rx_msg      <= msg_n;
            rx_parity   <= par_n;
            rx_complete <= done_n;
`ifdef UART_RX_FRAME_ERR_EN
            stop_bad    <= stop_bad_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; expected bytes and parity are computed here.
// Honours UART_RX_FRAME_ERR_EN the same way the design does.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk_3125;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       rx_complete;

    int n_checks = 0;
    int n_bad    = 0;

    logic [7:0] exp_msg = 8'h00;
    logic       exp_par = 1'b0;

    uart_rx #(.CLKS_PER_BIT(14), .ERR_CHAR(8'h3F)) dut (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_msg      (rx_msg),
        .rx_parity   (rx_parity),
        .rx_complete (rx_complete)
    );

    initial clk_3125 = 1'b0;
    always #160 clk_3125 = ~clk_3125;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Sends one frame starting at a falling clock edge; ends on the falling edge after
    // frame cycle 154, where the completion pulse must be visible.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic p, input logic s);
        logic [10:0] fr;
        int          pulses;
        logic        stable;
        logic [7:0]  m;
        fr     = {1'b0, d, p, s};
        pulses = 0;
        stable = 1'b1;
        for (int b = 0; b < 11; b++) begin
            rx = fr[10-b];
            for (int k = 0; k < 14; k++) begin
                @(negedge clk_3125);
                if (!(b == 10 && k == 13)) begin
                    if (rx_complete) pulses++;
                    if (rx_msg !== exp_msg || rx_parity !== exp_par) stable = 1'b0;
                end
            end
        end
        m = (p == ^d) ? d : 8'h3F;
`ifdef UART_RX_FRAME_ERR_EN
        if (!s) m = 8'h3F;
`endif
        exp_msg = m;
        exp_par = p;
        check({tag, "_early_pulse"}, pulses, 0);
        check({tag, "_hold"}, stable, 1);
        check({tag, "_complete"}, rx_complete, 1);
        check({tag, "_msg"}, rx_msg, exp_msg);
        check({tag, "_parity"}, rx_parity, exp_par);
    endtask

    task automatic idle_check(input string tag, input int n);
        int   pulses;
        logic stable;
        pulses = 0;
        stable = 1'b1;
        rx = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_3125);
            if (rx_complete) pulses++;
            if (rx_msg !== exp_msg || rx_parity !== exp_par) stable = 1'b0;
        end
        check({tag, "_no_pulse"}, pulses, 0);
        check({tag, "_hold"}, stable, 1);
    endtask

    initial begin
        logic [7:0] word [10];
        word = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h52, 8'h4C, 8'h44};

        // 1) reset state and quiet line
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk_3125);
        check("rst_msg", rx_msg, 8'h00);
        check("rst_parity", rx_parity, 0);
        check("rst_complete", rx_complete, 0);
        rst_n = 1'b1;
        idle_check("idle500", 500);

        // 2) 'A' with correct parity
        send_frame("frame_A", 8'h41, 1'b0, 1'b1);
        idle_check("after_A", 20);

        // 3) 0x43 with wrong parity
        send_frame("bad_par", 8'h43, 1'b0, 1'b1);
        idle_check("after_bad", 20);

        // 4) back-to-back "HELLO WRLD"
        for (int i = 0; i < 10; i++)
            send_frame($sformatf("b2b%0d", i), word[i], ^word[i], 1'b1);
        idle_check("after_b2b", 30);

        // 5a) short glitch is a false start
        rx = 1'b0;
        repeat (3) @(negedge clk_3125);
        idle_check("glitch", 200);

        // 5b) reset in the middle of the data bits
        rx = 1'b0;
        repeat (14) @(negedge clk_3125);
        rx = 1'b1;
        repeat (14) @(negedge clk_3125);
        rx = 1'b0;
        repeat (20) @(negedge clk_3125);
        rst_n = 1'b0;
        @(negedge clk_3125);
        check("midrst_msg", rx_msg, 8'h00);
        check("midrst_parity", rx_parity, 0);
        check("midrst_complete", rx_complete, 0);
        exp_msg = 8'h00;
        exp_par = 1'b0;
        rx = 1'b1;
        @(negedge clk_3125);
        rst_n = 1'b1;
        idle_check("after_midrst", 200);

        // 6) valid 0x52 with a low stop bit, then a normal frame to confirm re-arm
        send_frame("stop_low", 8'h52, 1'b1, 1'b0);
        idle_check("after_stop_low", 20);
        send_frame("rearm", 8'h41, 1'b0, 1'b1);
        idle_check("final", 20);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
